// File: rtl/conv_weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// conv_weight_loader_pkg
//
// Definitions shared by the weight loader and the convolution row /
// processing-element blocks it feeds:
//   - default geometry and widths (KERNEL_SIZE, NUM_ROWS, WEIGHT_BW, ADDR_BW)
//   - loader FSM state encoding
//   - helper deriving the number of weight writes in one load
// -----------------------------------------------------------------------------
package conv_weight_loader_pkg;

  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_NUM_ROWS    = 5;
  localparam int DEF_WEIGHT_BW   = 8;
  localparam int DEF_ADDR_BW     = 5;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_LOAD = ST_LOAD_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

  // One write per element of every row sharing the weight bus.
  function automatic int total_writes(input int kernel_size, input int num_rows);
    return kernel_size * num_rows;
  endfunction

endpackage

// File: rtl/conv_weight_loader.sv
// -----------------------------------------------------------------------------
// conv_weight_loader
//
// Weight-load sequencer for the broadcast weight bus of a stack of convolution
// row units. After i_start it accepts exactly TOTAL = KERNEL_SIZE*NUM_ROWS
// signed weights on a valid/ready stream and issues one registered write per
// accepted beat to consecutive element addresses starting at BASE_ADDR.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_start       begin a load (honoured only while idle)
//   i_s_valid     weight beat valid
//   o_s_ready     loader accepts a beat (registered, depends on state only)
//   i_s_data      signed weight value
//   i_s_last      producer's end-of-load marker, checked against the count
//   o_w_en        weight write strobe to the array
//   o_addr        element address of the write
//   o_w           weight value of the write
//   o_busy        load in progress
//   o_done        one-cycle pulse coincident with the final write
//   o_err         sticky framing error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module conv_weight_loader
  import conv_weight_loader_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int WEIGHT_BW   = DEF_WEIGHT_BW,
  parameter int ADDR_BW     = DEF_ADDR_BW,
  parameter int BASE_ADDR   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_s_valid,
  output logic                        o_s_ready,
  input  logic signed [WEIGHT_BW-1:0] i_s_data,
  input  logic                        i_s_last,
  output logic                        o_w_en,
  output logic        [ADDR_BW-1:0]   o_addr,
  output logic signed [WEIGHT_BW-1:0] o_w,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  localparam int TOTAL  = total_writes(KERNEL_SIZE, NUM_ROWS);
  localparam int CNT_BW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_BW-1:0]  LAST_CNT  = CNT_BW'(TOTAL - 1);
  localparam logic [ADDR_BW-1:0] BASE_VEC  = ADDR_BW'(BASE_ADDR);

  // The whole load must fit in the address space without wrapping.
  if (BASE_ADDR + TOTAL - 1 >= (1 << ADDR_BW)) begin : g_addr_range_check
    $error("conv_weight_loader: BASE_ADDR+TOTAL-1 does not fit in ADDR_BW bits");
  end

  state_e                       state_q, state_d;
  logic        [CNT_BW-1:0]     cnt_q, cnt_d;
  logic                         s_ready_q, s_ready_d;
  logic                         w_en_q, w_en_d;
  logic        [ADDR_BW-1:0]    addr_q, addr_d;
  logic signed [WEIGHT_BW-1:0]  w_q, w_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  logic handshake;
  logic last_beat;

  assign handshake = i_s_valid && s_ready_q;
  assign last_beat = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_ready_d = s_ready_q;
    w_en_d    = 1'b0;
    addr_d    = addr_q;   // address and weight hold between writes
    w_d       = w_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          err_d     = 1'b0;
          s_ready_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (handshake) begin
          w_en_d = 1'b1;
          addr_d = BASE_VEC + ADDR_BW'(cnt_q);
          w_d    = i_s_data;
          // Framing is only reported; the load length is fixed by the count.
          if (i_s_last != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d   = ST_DONE;
            cnt_d     = '0;
            s_ready_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      w_en_q    <= 1'b0;
      addr_q    <= '0;
      w_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      w_en_q    <= w_en_d;
      addr_q    <= addr_d;
      w_q       <= w_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_s_ready = s_ready_q;
  assign o_w_en    = w_en_q;
  assign o_addr    = addr_q;
  assign o_w       = w_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: doc/conv_weight_loader.md
# conv_weight_loader

Weight-load sequencer driving the broadcast weight bus (write enable, element address, weight value) of a stack of convolution row units. Accepts a stream of signed weights on a valid/ready handshake. Assigns consecutive element addresses starting at a base, and issues one registered write per accepted beat. Sits between the host-facing weight FIFO and the convolution array; it is the writer for the per-element weight registers, which latch on enable plus address match.

## Interface
Parameters:
- KERNEL_SIZE, 5, elements per row.
- NUM_ROWS, 5, rows sharing the weight bus; TOTAL = KERNEL_SIZE*NUM_ROWS writes per load.
- WEIGHT_BW, 8, weight width (signed).
- ADDR_BW, 5, element address width; BASE_ADDR+TOTAL-1 must be < 2^ADDR_BW (elaboration check).
- BASE_ADDR, 0, address of first element written.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: one clock; reset is synchronous and active-high.
- i_start, in, 1, begin a load; honoured only in IDLE.
- i_s_valid, in, 1, weight beat valid.
- o_s_ready, out, 1, loader accepts a beat.
- i_s_data, in, WEIGHT_BW signed, weight value.
- i_s_last, in, 1, producer marks final beat of the load.
- o_w_en, out, 1, weight write strobe to array.
- o_addr, out, ADDR_BW, element address.
- o_w, out, WEIGHT_BW signed, weight value.
- o_busy, out, 1, load in progress.
- o_done, out, 1, one-cycle pulse on load completion.
- o_err, out, 1, sticky framing error (i_s_last mismatch).

## Operation
- States: IDLE, LOAD, DONE. Beat counter cnt in 0..TOTAL-1.
- IDLE: o_s_ready=0. i_start=1 -> LOAD, cnt<=0, o_err<=0.
- LOAD: o_s_ready=1. On a handshake (i_s_valid & o_s_ready), the next cycle drives o_w_en=1, o_addr=BASE_ADDR+cnt, o_w=i_s_data. cnt increments.
- LOAD on handshake with cnt==TOTAL-1 -> DONE.
- No handshake -> o_w_en=0 next cycle. o_addr and o_w hold their last values.
- DONE: o_done=1, o_s_ready=0, -> IDLE unconditionally.
- Framing: o_err<=1 if i_s_last=1 on a beat with cnt<TOTAL-1, or i_s_last=0 on the beat with cnt==TOTAL-1.
- A framing error does not shorten or extend the load; exactly TOTAL beats are always consumed.
- o_err holds until the next accepted i_start or rst.
- i_start in LOAD or DONE is ignored.
- i_start and i_s_valid together in IDLE: start accepted, beat not consumed (ready=0 that cycle).
- o_busy = (state != IDLE).
- Address arithmetic is unsigned, no wrap within a load. The weight value passes through unmodified (no saturation).

## Timing
- Reset values: state IDLE, cnt 0, o_s_ready 0, o_w_en 0, o_addr 0, o_w 0, o_busy 0, o_done 0, o_err 0.
- Start latency: i_start at cycle S -> o_s_ready=1 at S+1.
- Write latency: handshake at T -> o_w_en at T+1. Back-to-back beats give one write per cycle.
- Final beat at T -> final o_w_en at T+1, coincident with o_done=1 and state DONE. o_busy=0 and IDLE at T+2.
- Earliest restart: i_start at T+2. Minimum load time TOTAL+2 cycles.
- rst mid-load: all outputs to reset values next cycle; the in-flight write is dropped. Array weights already written are left unchanged; the caller must reload.
- o_s_ready is a registered function of state only, with no combinational path from i_s_valid.

## Structure
- Shared package/include: state encodings (IDLE/LOAD/DONE localparams), TOTAL derivation, default KERNEL_SIZE/WEIGHT_BW/ADDR_BW shared with the row and processing-element blocks.
- Single flat module; counter and FSM inline, no sub-module.

## Test plan
- Nominal: TOTAL=25, BASE_ADDR=0, weights -12..12 streamed with continuous valid, last on beat 24 -> 25 consecutive writes, addr 0..24, o_w matching, o_done pulse with write 24, o_err=0.
- Backpressure/gaps: valid toggled 1-0-1 randomly -> o_w_en only on the cycles after handshakes, order preserved, o_addr/o_w held during gaps.
- Framing: last on beat 10 -> o_err=1 from cycle after beat 10, load still completes 25 writes. Then new start clears o_err.
- Ignored start: i_start pulsed during LOAD and in DONE -> no restart, cnt unaffected. Start with valid in IDLE -> that beat not consumed.
- Reset mid-load after 7 beats -> next cycle all outputs 0, IDLE. Fresh load writes addr 0..24 correctly.
- BASE_ADDR=5, NUM_ROWS=1 -> writes to addr 5..9, done after 5 beats, integrated with the row unit producing the expected psum for known x.
